axis_burst_reader: RTL and testbench
====================================

AXIS_BURST_READER -- requirements
Module: axis_burst_reader

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32: data word width in bits.
REQ-002 Parameter CNTR_WIDTH, default 10: width of burst length and FIFO occupancy.
REQ-003 Parameter TIMEOUT_WIDTH, default 16: width of the timeout setting.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 aclk  input  1  sole clock; all logic on rising edge.
REQ-006 aresetn  input  1  synchronous active-low reset.
REQ-007 cfg_data  input  CNTR_WIDTH  burst length in words; 0 means disabled.
REQ-008 cfg_timeout  input  TIMEOUT_WIDTH  partial-burst timeout in cycles; 0 means disabled.
REQ-009 fifo_count  input  CNTR_WIDTH  occupancy reported by the upstream sync FIFO.
REQ-010 s_axis_tdata / s_axis_tvalid / s_axis_tready  in/in/out  AXIS_TDATA_WIDTH/1/1  stream from the FIFO.
REQ-011 m_axis_tdata / m_axis_tvalid / m_axis_tready / m_axis_tlast  out/out/in/out  AXIS_TDATA_WIDTH/1/1/1  burst stream.
REQ-012 busy  output  1  high while in BURST state.
REQ-013 sts_bursts  output  32  count of completed bursts, wraps modulo 2^32.

Function
REQ-014 The FSM SHALL have two states, IDLE and BURST.
REQ-015 In IDLE, s_axis_tready SHALL be 0.
REQ-016 IDLE->BURST SHALL occur on the edge where cfg_data != 0 and fifo_count >= cfg_data; remaining-word counter loaded with cfg_data.
REQ-017 cfg_data SHALL be sampled only at burst start; changes during BURST are ignored.
REQ-018 In BURST, s_axis_tready SHALL equal the output stage's ready; each s_axis handshake decrements the remaining counter by 1.
REQ-019 The word accepted when remaining == 1 SHALL carry tlast=1; all others tlast=0.
REQ-020 On acceptance of the tlast word, the FSM SHALL return to IDLE on the next edge and sts_bursts SHALL increment by 1.
REQ-021 A new burst SHALL NOT start in the cycle the previous one ends; minimum one IDLE cycle between bursts.
REQ-022 tdata and tlast SHALL pass through one registered output stage; input-to-output latency is 1 cycle with no bubbles at sustained tready=1.
REQ-023 The output stage SHALL hold m_axis_tdata/tlast/tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-024 s_axis_tvalid=0 mid-burst SHALL stall the burst without a state change or counter loss.
REQ-025 busy SHALL be 1 exactly while the state is BURST.

Reset
REQ-026 On aresetn=0 at a rising edge: state=IDLE, remaining=0, sts_bursts=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0, s_axis_tready=0.
REQ-027 Reset mid-burst SHALL abort the burst; any buffered output word is discarded; sts_bursts is not incremented.
REQ-028 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-029 Macro AXIS_BURST_READER_TIMEOUT_EN SHALL enable partial-burst flushing.
REQ-030 With the macro: in IDLE, an idle counter increments while 0 < fifo_count < cfg_data; it clears when fifo_count == 0, on burst start, or when cfg_timeout == 0.
REQ-031 With the macro: when the idle counter reaches cfg_timeout (nonzero), a burst of length fifo_count SHALL start with normal tlast rules.
REQ-032 Without the macro: cfg_timeout SHALL be ignored, there is no idle counter, and only full bursts occur.

Structure
REQ-033 No shared package; the FSM state encoding is a local constant.
REQ-034 The registered output stage SHALL be the existing output_buffer sub-module, instantiated with DATA_WIDTH = AXIS_TDATA_WIDTH+1 (tdata plus tlast).

Verification
REQ-035 cfg_data=4, fifo_count=3 held -> no s_axis handshake, busy=0; fifo_count=4 -> exactly 4 words out, tlast on the 4th, sts_bursts=1.
REQ-036 cfg_data=8, m_axis_tready toggling 1/0 every cycle, data 0..7 -> output 0..7 in order, no duplicates or drops, data stable while stalled.
REQ-037 cfg_data=4 at burst start, changed to 2 after the 1st word -> burst still 4 words long.
REQ-038 cfg_data=16, aresetn=0 after 5 words -> m_axis_tvalid=0 next cycle, sts_bursts=0, state IDLE.
REQ-039 With macro: cfg_data=16, cfg_timeout=10, fifo_count=3 held -> burst of 3 words with tlast on the 3rd, starting after 10 idle cycles.
REQ-040 Without macro, same stimulus as REQ-039 -> no output for 1000 cycles.

Source files
------------

// File: rtl/output_buffer.sv
// Single registered pipeline stage with valid/ready handshake.
// Accepts a new word whenever the register is empty or is being drained, so it sustains full rate.
module output_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  load;

  assign s_ready = !valid_q || m_ready;
  assign load    = s_valid && s_ready;
  assign m_data  = data_q;
  assign m_valid = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = s_data;
      valid_d = 1'b1;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/axis_burst_reader.sv
// Pulls fixed-length bursts from an upstream FIFO once enough words are queued and marks the last word.
// Define AXIS_BURST_READER_TIMEOUT_EN to flush partial bursts after cfg_timeout idle cycles.
module axis_burst_reader #(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH       = 10,
  parameter int unsigned TIMEOUT_WIDTH    = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
  input  logic [CNTR_WIDTH-1:0]       fifo_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic [31:0]                 sts_bursts
);

  localparam int unsigned BUF_W = AXIS_TDATA_WIDTH + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNTR_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]           bursts_q, bursts_d;

  logic             buf_in_ready;
  logic             buf_in_valid;
  logic [BUF_W-1:0] buf_in_data;
  logic [BUF_W-1:0] buf_out_data;
  logic             in_hs;
  logic             last_word;
  logic             full_ready;

  assign full_ready    = (cfg_data != '0) && (fifo_count >= cfg_data);
  assign last_word     = (remaining_q == CNTR_WIDTH'(1));
  assign s_axis_tready = (state_q == BURST) && buf_in_ready;
  assign in_hs         = s_axis_tready && s_axis_tvalid;
  assign buf_in_valid  = (state_q == BURST) && s_axis_tvalid;
  assign buf_in_data   = {last_word, s_axis_tdata};

`ifdef AXIS_BURST_READER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic                     partial_pending;
  logic                     timeout_hit;

  // A partial burst is waiting: some words queued but fewer than a full burst.
  assign partial_pending = (cfg_timeout != '0) && (fifo_count != '0) && (fifo_count < cfg_data);
  assign timeout_hit     = partial_pending && (idle_cnt_q >= cfg_timeout);
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    bursts_d    = bursts_q;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif
    if (state_q == IDLE) begin
`ifdef AXIS_BURST_READER_TIMEOUT_EN
      if ((cfg_timeout == '0) || (fifo_count == '0)) begin
        idle_cnt_d = '0;
      end else if (partial_pending) begin
        idle_cnt_d = idle_cnt_q + TIMEOUT_WIDTH'(1);
      end
`endif
      if (full_ready) begin
        state_d     = BURST;
        remaining_d = cfg_data;
`ifdef AXIS_BURST_READER_TIMEOUT_EN
        idle_cnt_d  = '0;
      end else if (timeout_hit) begin
        state_d     = BURST;
        remaining_d = fifo_count;
        idle_cnt_d  = '0;
`endif
      end
    end else begin
      // Burst ends on the handshake of the tlast word; the next edge always lands in IDLE.
      if (in_hs) begin
        remaining_d = remaining_q - CNTR_WIDTH'(1);
        if (last_word) begin
          state_d  = IDLE;
          bursts_d = bursts_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      bursts_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      bursts_q    <= bursts_d;
    end
  end

`ifdef AXIS_BURST_READER_TIMEOUT_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  output_buffer #(
    .DATA_WIDTH(BUF_W)
  ) u_out_buf (
    .clk    (aclk),
    .rst_n  (aresetn),
    .s_data (buf_in_data),
    .s_valid(buf_in_valid),
    .s_ready(buf_in_ready),
    .m_data (buf_out_data),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready)
  );

  assign m_axis_tdata = buf_out_data[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast = buf_out_data[AXIS_TDATA_WIDTH];
  assign busy         = (state_q == BURST);
  assign sts_bursts   = bursts_q;

endmodule

// File: tb/tb_axis_burst_reader.sv
// Directed bench for axis_burst_reader; the upstream FIFO is modelled as a level plus an incrementing data index.
// Build with AXIS_BURST_READER_TIMEOUT_EN to exercise partial-burst flushing.
module tb_axis_burst_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 10;
  localparam int unsigned TW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [CW-1:0] cfg_data;
  logic [TW-1:0] cfg_timeout;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic [31:0]   sts_bursts;

  always #5 aclk = ~aclk;

  axis_burst_reader #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH      (CW),
    .TIMEOUT_WIDTH   (TW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_data     (cfg_data),
    .cfg_timeout  (cfg_timeout),
    .fifo_count   (fifo_count),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .sts_bursts   (sts_bursts)
  );

  int          vectors;
  int          miscompares;
  int          fifo_level;
  int          in_hs_cnt;
  int          step_cnt;
  int          first_busy;
  logic [31:0] src_idx;
  logic [31:0] out_q[$];
  logic        last_q[$];
  bit          stall_prev;
  logic [32:0] stall_word;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    fifo_count    = CW'(fifo_level);
    s_axis_tvalid = (fifo_level > 0);
    s_axis_tdata  = src_idx;
  endtask

  // One clock: sample handshakes mid-cycle, then update the FIFO model just after the edge.
  task automatic step();
    logic          ihs, ohs, ol;
    logic [DW-1:0] od;
    @(negedge aclk);
    ihs = s_axis_tvalid && s_axis_tready;
    ohs = m_axis_tvalid && m_axis_tready;
    od  = m_axis_tdata;
    ol  = m_axis_tlast;
    if (stall_prev)
      check("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, stall_word}));
    stall_prev = m_axis_tvalid && !m_axis_tready && aresetn;
    stall_word = {ol, od};
    @(posedge aclk);
    #1;
    if (ihs) begin
      fifo_level--;
      src_idx++;
      in_hs_cnt++;
    end
    if (ohs) begin
      out_q.push_back(od);
      last_q.push_back(ol);
    end
    step_cnt++;
    if (busy && first_busy < 0) first_busy = step_cnt;
    drive_src();
  endtask

  task automatic clear_obs();
    out_q.delete();
    last_q.delete();
    in_hs_cnt  = 0;
    step_cnt   = 0;
    first_busy = -1;
  endtask

  task automatic run_until(input int n_words, input int budget);
    int guard;
    guard = 0;
    while (out_q.size() < n_words && guard < budget) begin
      step();
      guard++;
    end
  endtask

  initial begin
    logic [31:0] base;
    vectors       = 0;
    miscompares   = 0;
    fifo_level    = 0;
    src_idx       = '0;
    stall_prev    = 1'b0;
    stall_word    = '0;
    aresetn       = 1'b0;
    cfg_data      = '0;
    cfg_timeout   = '0;
    m_axis_tready = 1'b1;
    clear_obs();
    drive_src();
    step();
    step();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_sts", 64'(sts_bursts), 64'd0);

    // Not enough words queued: nothing moves.
    aresetn    = 1'b1;
    cfg_data   = CW'(4);
    fifo_level = 3;
    drive_src();
    clear_obs();
    for (int i = 0; i < 10; i++) step();
    check("short_no_hs", 64'(in_hs_cnt), 64'd0);
    check("short_busy", 64'(busy), 64'd0);

    // Fourth word arrives: one burst of 4.
    fifo_level = 4;
    drive_src();
    run_until(4, 30);
    for (int i = 0; i < 3; i++) step();
    check("b4_count", 64'(out_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      check("b4_data", 64'(out_q[i]), 64'(i));
      check("b4_last", 64'(last_q[i]), 64'(i == 3));
    end
    check("b4_sts", 64'(sts_bursts), 64'd1);
    check("b4_busy_after", 64'(busy), 64'd0);

    // Burst of 8 with downstream ready toggling every cycle.
    clear_obs();
    base       = src_idx;
    cfg_data   = CW'(8);
    fifo_level = 8;
    drive_src();
    for (int g = 0; g < 60 && out_q.size() < 8; g++) begin
      m_axis_tready = ~m_axis_tready;
      step();
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("b8_count", 64'(out_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      check("b8_data", 64'(out_q[i]), 64'(base + 32'(i)));
      check("b8_last", 64'(last_q[i]), 64'(i == 7));
    end
    check("b8_sts", 64'(sts_bursts), 64'd2);

    // cfg_data changed mid-burst must not shorten it.
    clear_obs();
    base       = src_idx;
    cfg_data   = CW'(4);
    fifo_level = 4;
    drive_src();
    run_until(1, 20);
    cfg_data = CW'(2);
    run_until(4, 20);
    for (int i = 0; i < 3; i++) step();
    check("cfgchg_count", 64'(out_q.size()), 64'd4);
    if (out_q.size() == 4) begin
      check("cfgchg_last3", 64'(last_q[3]), 64'd1);
      check("cfgchg_last1", 64'(last_q[1]), 64'd0);
      check("cfgchg_data3", 64'(out_q[3]), 64'(base + 32'd3));
    end
    check("cfgchg_sts", 64'(sts_bursts), 64'd3);

    // Reset in the middle of a 16-word burst.
    clear_obs();
    cfg_data   = CW'(16);
    fifo_level = 16;
    drive_src();
    run_until(5, 30);
    check("abort_busy_before", 64'(busy), 64'd1);
    aresetn = 1'b0;
    step();
    check("abort_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sts", 64'(sts_bursts), 64'd0);
    check("abort_s_tready", 64'(s_axis_tready), 64'd0);
    fifo_level = 0;
    drive_src();
    aresetn = 1'b1;
    step();

    // cfg_data == 0 disables bursts even with words queued.
    clear_obs();
    cfg_data   = '0;
    fifo_level = 5;
    drive_src();
    for (int i = 0; i < 8; i++) step();
    check("dis_no_hs", 64'(in_hs_cnt), 64'd0);
    fifo_level = 0;
    drive_src();
    step();

    // Partial burst with a timeout configured.
    clear_obs();
    cfg_data    = CW'(16);
    cfg_timeout = TW'(10);
    fifo_level  = 3;
    base        = src_idx;
    drive_src();
`ifdef AXIS_BURST_READER_TIMEOUT_EN
    run_until(3, 40);
    for (int i = 0; i < 3; i++) step();
    check("to_first_busy", 64'(first_busy), 64'd11);
    check("to_count", 64'(out_q.size()), 64'd3);
    if (out_q.size() == 3) begin
      check("to_last", 64'(last_q[2]), 64'd1);
      check("to_last0", 64'(last_q[0]), 64'd0);
      check("to_data2", 64'(out_q[2]), 64'(base + 32'd2));
    end
    check("to_sts", 64'(sts_bursts), 64'd1);
`else
    for (int i = 0; i < 1000; i++) step();
    check("to_no_out", 64'(out_q.size()), 64'd0);
    check("to_never_busy", 64'(first_busy), 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_sts", 64'(sts_bursts), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
